// File: rtl/dose_scheduler.sv
// Dose scheduler: matches programmable dose times against time-of-day and dispatches
// pending doses lowest-slot-first over a req/done handshake with a timeout fault.
module dose_scheduler #(
  parameter int SLOTS        = 4,
  parameter int DONE_TIMEOUT = 30,
  localparam int SW          = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       hours,
  input  logic [5:0]       minutes,
  input  logic [5:0]       seconds,
  input  logic             time_valid,
  input  logic             sec_tick,
  input  logic             cfg_we,
  input  logic [SW-1:0]    cfg_slot,
  input  logic             cfg_enable,
  input  logic [4:0]       cfg_hours,
  input  logic [5:0]       cfg_minutes,
  input  logic [5:0]       cfg_seconds,
  input  logic             fault_clr,
  output logic             dispense_req,
  output logic [SW-1:0]    dispense_slot,
  input  logic             dispense_done,
  output logic [SLOTS-1:0] pending,
  output logic             busy,
  output logic             fault,
  output logic             alarm
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(DONE_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [SLOTS-1:0] pending_q, pending_d;
  logic [SLOTS-1:0] en_q, en_d;
  logic [4:0]       hr_q  [SLOTS];
  logic [4:0]       hr_d  [SLOTS];
  logic [5:0]       min_q [SLOTS];
  logic [5:0]       min_d [SLOTS];
  logic [5:0]       sec_q [SLOTS];
  logic [5:0]       sec_d [SLOTS];

  logic             cfg_ok;
  logic [SLOTS-1:0] match_vec;
  logic [SLOTS-1:0] dis_clr;
  logic [SLOTS-1:0] grant_clr;
  logic [SLOTS-1:0] grant_oh;
  logic [SW-1:0]    grant_idx;
  logic [7:0]       cnt_inc;

  // Out-of-range times are rejected as a whole, including the enable bit.
  assign cfg_ok = cfg_we && (cfg_hours <= 5'd23) && (cfg_minutes <= 6'd59) && (cfg_seconds <= 6'd59);

  always_comb begin
    en_d      = en_q;
    match_vec = '0;
    dis_clr   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      hr_d[i]  = hr_q[i];
      min_d[i] = min_q[i];
      sec_d[i] = sec_q[i];
      match_vec[i] = sec_tick && time_valid && en_q[i] &&
                     (hr_q[i] == hours) && (min_q[i] == minutes) && (sec_q[i] == seconds);
      if (cfg_ok && (cfg_slot == SW'(i))) begin
        en_d[i]    = cfg_enable;
        hr_d[i]    = cfg_hours;
        min_d[i]   = cfg_minutes;
        sec_d[i]   = cfg_seconds;
        dis_clr[i] = !cfg_enable;
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant_idx = SW'(i);
      end
    end
    grant_oh = SLOTS'(1) << grant_idx;
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    grant_clr = '0;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          grant_clr = grant_oh;
          slot_d    = grant_idx;
          cnt_d     = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Completion takes precedence over a coincident final timeout tick.
        if (dispense_done) begin
          state_d = ST_IDLE;
        end else if (sec_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new match outranks a grant or disable clearing the same bit.
  assign pending_d = (pending_q & ~(grant_clr | dis_clr)) | match_vec;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      slot_q    <= '0;
      pending_q <= '0;
      en_q      <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        hr_q[i]  <= '0;
        min_q[i] <= '0;
        sec_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      pending_q <= pending_d;
      en_q      <= en_d;
      for (int i = 0; i < SLOTS; i++) begin
        hr_q[i]  <= hr_d[i];
        min_q[i] <= min_d[i];
        sec_q[i] <= sec_d[i];
      end
    end
  end

  assign dispense_req  = (state_q == ST_WAIT);
  assign dispense_slot = slot_q;
  assign pending       = pending_q;
  assign busy          = (state_q != ST_IDLE);
  assign fault         = (state_q == ST_FAULT);
  assign alarm         = fault;

endmodule

// File: tb/tb_dose_scheduler.sv
// Bench for dose_scheduler: directed scenarios plus randomized traffic against a behavioural model.
module tb_dose_scheduler;
  localparam int TO = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] hours = '0;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic       time_valid = 1'b1;
  logic       sec_tick = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_slot = '0;
  logic       cfg_enable = 1'b0;
  logic [4:0] cfg_hours = '0;
  logic [5:0] cfg_minutes = '0;
  logic [5:0] cfg_seconds = '0;
  logic       fault_clr = 1'b0;
  logic       dispense_done = 1'b0;
  logic       dispense_req;
  logic [1:0] dispense_slot;
  logic [3:0] pending;
  logic       busy;
  logic       fault;
  logic       alarm;

  int n_vec = 0;
  int n_err = 0;

  dose_scheduler #(.SLOTS(4), .DONE_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .hours(hours), .minutes(minutes), .seconds(seconds),
    .time_valid(time_valid), .sec_tick(sec_tick), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
    .cfg_enable(cfg_enable), .cfg_hours(cfg_hours), .cfg_minutes(cfg_minutes),
    .cfg_seconds(cfg_seconds), .fault_clr(fault_clr), .dispense_req(dispense_req),
    .dispense_slot(dispense_slot), .dispense_done(dispense_done), .pending(pending),
    .busy(busy), .fault(fault), .alarm(alarm)
  );

  always #5 clock = ~clock;

  // Behavioural model: slot table, set of due doses, and a dispenser activity mode.
  bit         m_en  [4];
  int         m_h   [4];
  int         m_m   [4];
  int         m_s   [4];
  bit         m_due [4];
  int         m_mode;   // 0 idle, 1 dispensing, 2 faulted
  int         m_slot;
  int         m_ticks;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_en[i] = 0; m_h[i] = 0; m_m[i] = 0; m_s[i] = 0; m_due[i] = 0;
    end
    m_mode = 0; m_slot = 0; m_ticks = 0;
  endfunction

  function automatic void model_step();
    bit hit [4];
    bit drop [4];
    bit wr_ok;
    for (int i = 0; i < 4; i++) begin
      hit[i]  = sec_tick && time_valid && m_en[i] && m_h[i] == int'(hours) &&
                m_m[i] == int'(minutes) && m_s[i] == int'(seconds);
      drop[i] = 0;
    end
    wr_ok = cfg_we && cfg_hours <= 23 && cfg_minutes <= 59 && cfg_seconds <= 59;
    if (wr_ok && !cfg_enable) drop[cfg_slot] = 1;
    if (m_mode == 0) begin
      for (int i = 3; i >= 0; i--) if (m_due[i]) m_slot = i;
      if (m_due[0] || m_due[1] || m_due[2] || m_due[3]) begin
        drop[m_slot] = 1; m_ticks = 0; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (dispense_done) m_mode = 0;
      else if (sec_tick) begin
        m_ticks++;
        if (m_ticks == TO) m_mode = 2;
      end
    end else if (fault_clr) begin
      m_mode = 0;
    end
    for (int i = 0; i < 4; i++) m_due[i] = hit[i] || (m_due[i] && !drop[i]);
    if (wr_ok) begin
      m_en[cfg_slot] = cfg_enable; m_h[cfg_slot] = cfg_hours;
      m_m[cfg_slot] = cfg_minutes; m_s[cfg_slot] = cfg_seconds;
    end
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clock); #1;
    sec_tick = 0; cfg_we = 0; fault_clr = 0; dispense_done = 0;
  endtask

  task automatic set_time(input int h, input int m, input int s, input bit tick);
    hours = 5'(h); minutes = 6'(m); seconds = 6'(s); sec_tick = tick;
  endtask

  task automatic write_slot(input int sl, input bit en, input int h, input int m, input int s);
    cfg_we = 1; cfg_slot = 2'(sl); cfg_enable = en;
    cfg_hours = 5'(h); cfg_minutes = 6'(m); cfg_seconds = 6'(s);
    cyc();
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    reset = 0; model_reset();
    #4;
    reset = 1;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    if (dispense_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", dispense_req); end n_vec++;
    if (dispense_slot !== 2'd0) begin n_err++; $display("FAIL reset_slot: got %0d want 0", dispense_slot); end n_vec++;
    if (pending !== 4'b0) begin n_err++; $display("FAIL reset_pending: got %b want 0000", pending); end n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end n_vec++;
    if (fault !== 1'b0 || alarm !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b%b want 00", fault, alarm); end n_vec++;
  endtask

  task automatic test_basic();
    write_slot(0, 1, 8, 0, 0);
    set_time(8, 0, 0, 1); cyc();
    if (pending !== 4'b0001 || dispense_req !== 1'b0) begin n_err++; $display("FAIL basic_pending: got %b req %b want 0001 req 0", pending, dispense_req); end n_vec++;
    cyc();
    if (dispense_req !== 1'b1 || dispense_slot !== 2'd0) begin n_err++; $display("FAIL basic_req: got req %b slot %0d want 1 slot 0", dispense_req, dispense_slot); end n_vec++;
    if (pending !== 4'b0 || busy !== 1'b1) begin n_err++; $display("FAIL basic_grant: got pending %b busy %b want 0000 1", pending, busy); end n_vec++;
    repeat (4) cyc();
    if (dispense_req !== 1'b1) begin n_err++; $display("FAIL basic_hold: got %b want 1", dispense_req); end n_vec++;
    dispense_done = 1; cyc();
    if (dispense_req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_done: got req %b busy %b want 0 0", dispense_req, busy); end n_vec++;
  endtask

  task automatic test_priority();
    write_slot(2, 1, 12, 30, 15);
    write_slot(1, 1, 12, 30, 15);
    set_time(12, 30, 15, 1); cyc();
    if (pending !== 4'b0110) begin n_err++; $display("FAIL prio_pending: got %b want 0110", pending); end n_vec++;
    cyc();
    if (dispense_req !== 1'b1 || dispense_slot !== 2'd1 || pending !== 4'b0100) begin n_err++; $display("FAIL prio_first: got req %b slot %0d pend %b want 1 1 0100", dispense_req, dispense_slot, pending); end n_vec++;
    dispense_done = 1; cyc();
    if (dispense_req !== 1'b0 || dispense_slot !== 2'd1) begin n_err++; $display("FAIL prio_gap: got req %b slot %0d want 0 1", dispense_req, dispense_slot); end n_vec++;
    cyc();
    if (dispense_req !== 1'b1 || dispense_slot !== 2'd2 || pending !== 4'b0) begin n_err++; $display("FAIL prio_second: got req %b slot %0d pend %b want 1 2 0000", dispense_req, dispense_slot, pending); end n_vec++;
    dispense_done = 1; cyc();
  endtask

  task automatic test_timeout();
    write_slot(3, 1, 6, 0, 0);
    set_time(6, 0, 0, 1); cyc();
    cyc();
    if (dispense_req !== 1'b1 || dispense_slot !== 2'd3) begin n_err++; $display("FAIL to_req: got req %b slot %0d want 1 3", dispense_req, dispense_slot); end n_vec++;
    set_time(6, 0, 1, 1); cyc();
    set_time(6, 0, 2, 1); cyc();
    if (fault !== 1'b0) begin n_err++; $display("FAIL to_early: got %b want 0", fault); end n_vec++;
    set_time(6, 0, 3, 1); cyc();
    if (fault !== 1'b1 || alarm !== 1'b1 || dispense_req !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL to_fault: got f%b a%b r%b b%b want 1 1 0 1", fault, alarm, dispense_req, busy); end n_vec++;
    set_time(6, 0, 0, 1); cyc();
    if (pending !== 4'b1000 || fault !== 1'b1) begin n_err++; $display("FAIL to_match_in_fault: got pend %b fault %b want 1000 1", pending, fault); end n_vec++;
    dispense_done = 1; cyc();
    if (fault !== 1'b1) begin n_err++; $display("FAIL to_done_ignored: got %b want 1", fault); end n_vec++;
    fault_clr = 1; cyc();
    if (fault !== 1'b0 || busy !== 1'b0 || pending !== 4'b1000) begin n_err++; $display("FAIL to_clear: got f%b b%b pend %b want 0 0 1000", fault, busy, pending); end n_vec++;
    cyc();
    if (dispense_req !== 1'b1 || dispense_slot !== 2'd3) begin n_err++; $display("FAIL to_redispatch: got req %b slot %0d want 1 3", dispense_req, dispense_slot); end n_vec++;
    dispense_done = 1; cyc();
  endtask

  task automatic test_suppress();
    time_valid = 0; set_time(8, 0, 0, 1); cyc();
    time_valid = 1;
    if (pending !== 4'b0) begin n_err++; $display("FAIL sup_invalid_time: got %b want 0000", pending); end n_vec++;
    write_slot(0, 0, 24, 0, 0);
    set_time(8, 0, 0, 1); cyc();
    if (pending !== 4'b0001) begin n_err++; $display("FAIL sup_bad_cfg: got %b want 0001", pending); end n_vec++;
    cyc();
    dispense_done = 1; cyc();
    set_time(12, 30, 15, 1); cyc();
    cyc();
    if (pending !== 4'b0100) begin n_err++; $display("FAIL sup_pre_disable: got %b want 0100", pending); end n_vec++;
    write_slot(2, 0, 12, 30, 15);
    if (pending !== 4'b0000) begin n_err++; $display("FAIL sup_disable: got %b want 0000", pending); end n_vec++;
    dispense_done = 1; cyc();
    cyc(); cyc();
    if (dispense_req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL sup_no_dispense: got req %b busy %b want 0 0", dispense_req, busy); end n_vec++;
  endtask

  task automatic test_races();
    set_time(6, 0, 0, 1); cyc();
    cyc();
    set_time(6, 0, 1, 1); cyc();
    set_time(6, 0, 2, 1); cyc();
    set_time(6, 0, 3, 1); dispense_done = 1; cyc();
    if (fault !== 1'b0 || busy !== 1'b0 || dispense_req !== 1'b0) begin n_err++; $display("FAIL race_done_tick: got f%b b%b r%b want 0 0 0", fault, busy, dispense_req); end n_vec++;
    set_time(8, 0, 0, 1); cyc();
    set_time(8, 0, 0, 1); cyc();
    if (dispense_req !== 1'b1 || dispense_slot !== 2'd0 || pending !== 4'b0001) begin n_err++; $display("FAIL race_grant_match: got r%b s%0d p%b want 1 0 0001", dispense_req, dispense_slot, pending); end n_vec++;
    dispense_done = 1; cyc();
    cyc();
    if (dispense_req !== 1'b1 || dispense_slot !== 2'd0 || pending !== 4'b0) begin n_err++; $display("FAIL race_second: got r%b s%0d p%b want 1 0 0000", dispense_req, dispense_slot, pending); end n_vec++;
    dispense_done = 1; cyc();
  endtask

  task automatic test_async_reset();
    set_time(6, 0, 0, 1); cyc();
    cyc();
    if (dispense_req !== 1'b1) begin n_err++; $display("FAIL ar_pre: got %b want 1", dispense_req); end n_vec++;
    #2 reset = 0; model_reset();
    #1;
    if (dispense_req !== 1'b0) begin n_err++; $display("FAIL ar_req_drop: got %b want 0", dispense_req); end n_vec++;
    if ({dispense_slot, pending, busy, fault, alarm} !== 9'b0) begin n_err++; $display("FAIL ar_outputs: got %b want 0", {dispense_slot, pending, busy, fault, alarm}); end n_vec++;
    #2 reset = 1;
    cyc();
    set_time(6, 0, 0, 1); cyc();
    set_time(8, 0, 0, 1); cyc();
    set_time(12, 30, 15, 1); cyc();
    if (pending !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL ar_slots_cleared: got p%b b%b want 0000 0", pending, busy); end n_vec++;
  endtask

  task automatic test_random();
    logic [9:0] got, exp;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cfg_we      = ($urandom % 6) == 0;
      cfg_slot    = 2'($urandom % 4);
      cfg_enable  = ($urandom % 4) != 0;
      cfg_hours   = (($urandom % 12) == 0) ? 5'(24 + $urandom % 8) : 5'($urandom % 2);
      cfg_minutes = (($urandom % 12) == 0) ? 6'(60) : 6'd0;
      cfg_seconds = 6'($urandom % 4);
      hours       = 5'($urandom % 2);
      minutes     = (($urandom % 10) == 0) ? 6'd1 : 6'd0;
      seconds     = 6'($urandom % 4);
      time_valid  = ($urandom % 8) != 0;
      sec_tick    = ($urandom % 3) == 0;
      dispense_done = ($urandom % 6) == 0;
      fault_clr   = ($urandom % 8) == 0;
      cyc();
      got = {dispense_req, dispense_slot, pending, busy, fault, alarm};
      exp = {m_mode == 1, 2'(m_slot), m_due[3], m_due[2], m_due[1], m_due[0],
             m_mode != 0, m_mode == 2, m_mode == 2};
      if (got !== exp) begin n_err++; $display("FAIL rand_cycle_%0d: got %b want %b", n, got, exp); end n_vec++;
    end
    time_valid = 1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_priority();
    test_timeout();
    test_suppress();
    test_races();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dose_scheduler.md
# dose_scheduler

Dose scheduler for the dispenser. It holds SLOTS programmable dose times (hh:mm:ss) and compares them against the running time-of-day from the clock block. When a slot matches, it marks a pending dose. Pending doses are dispatched one at a time, lowest slot first, to the dispenser motor through a req/done handshake, and a missing done raises a latched fault with an alarm.

## Interface
Parameters:
- SLOTS, 4, number of dose-time slots (slot index width SW = clog2(SLOTS), 2 at default)
- DONE_TIMEOUT, 30, seconds allowed for dispense_done, counted in sec_tick pulses; range 1..255

Ports:
- clock  in  1  system clock; all state changes on posedge
- reset  in  1  asynchronous, active-low; 0 = reset
- hours  in  5  current hour, 0..23
- minutes  in  6  current minute, 0..59
- seconds  in  6  current second, 0..59
- time_valid  in  1  1 = time is running (clock mode); 0 while the time is being set
- sec_tick  in  1  one-cycle pulse each time seconds advances
- cfg_we  in  1  one-cycle write strobe for slot configuration
- cfg_slot  in  SW  slot to write
- cfg_enable  in  1  enable bit written to the slot
- cfg_hours  in  5  dose hour written to the slot
- cfg_minutes  in  6  dose minute written to the slot
- cfg_seconds  in  6  dose second written to the slot
- fault_clr  in  1  one-cycle pulse; clears the fault
- dispense_req  out  1  request to the motor to dispense one dose
- dispense_slot  out  SW  slot being dispensed
- dispense_done  in  1  motor completion pulse or level
- pending  out  SLOTS  per-slot bit; 1 = dose due but not yet dispatched
- busy  out  1  1 = FSM not in IDLE
- fault  out  1  latched dispense timeout
- alarm  out  1  buzzer drive; equals fault

## Operation
- Reset (asynchronous): all slots disabled with time 00:00:00, pending=0, state IDLE, timeout counter 0, dispense_req=0, dispense_slot=0, busy=0, fault=0, alarm=0.
- Config write (cfg_we=1): the slot takes enable/h/m/s on the next edge.
  - Write ignored entirely if cfg_hours>23, cfg_minutes>59 or cfg_seconds>59.
  - Writing enable=0 also clears that slot's pending bit.
  - Writes are accepted in every state.
- Match:
  - Condition: sec_tick=1, time_valid=1, slot enabled, and slot h/m/s equal to the inputs.
  - Result: that slot's pending bit is set.
  - Only sec_tick cycles are evaluated, so a slot fires at most once per second-value. With time_valid=0, no matches occur and the missed dose is not recovered.
- Pending bit:
  - If set and clear occur in the same cycle, set wins.
  - A set on an already-pending bit has no effect; no counting.
- FSM states:
  - IDLE: if pending≠0, grant the lowest set index. Clear its pending bit, load dispense_slot, zero the timeout counter, and go to WAIT. Otherwise stay in IDLE.
  - WAIT: dispense_req=1. If dispense_done=1, go to IDLE. Otherwise, on sec_tick the counter increments; when the counter reaches DONE_TIMEOUT, go to FAULT. If done and the final tick arrive in the same cycle, done wins.
  - FAULT: dispense_req=0, fault=alarm=1. Matches still set pending bits. A fault_clr pulse returns the FSM to IDLE.
- dispense_done is ignored outside WAIT. fault_clr is ignored outside FAULT.
- dispense_slot holds its last granted value after the request ends.

## Timing
- Match latency:
  - sec_tick sampled at edge N → pending bit set after edge N.
  - IDLE grants at edge N+1 → dispense_req=1 after edge N+1.
- Handshake: dispense_req stays high until dispense_done is sampled high, then falls after that same edge. dispense_slot is stable for the whole request.
- Gap: dispense_req is low for at least one full cycle between consecutive dispenses (one IDLE cycle).
- Timeout: FAULT is entered on the edge sampling the DONE_TIMEOUT-th sec_tick counted in WAIT. The sec_tick in the grant cycle is not counted.
- Async reset mid-dispense drops dispense_req immediately, without waiting for a clock edge. The dose in flight is lost.
- busy is registered with state and is high in WAIT and FAULT.

## Test plan
- Basic dose: slot0 enabled at 08:00:00; drive time 08:00:00 with a sec_tick; return done 5 cycles after req. Required: pending[0] high 1 cycle, then req=1 with slot=0, req=0 after done, busy back to 0.
- Priority: slots 2 and 1 both set to 12:30:15 and matched together. Required: pending=0110; slot 1 dispensed first; slot 2 dispensed after ≥1 idle cycle.
- Timeout: with DONE_TIMEOUT=3, never assert done. Required: fault=alarm=1 on the 3rd sec_tick, req=0. A match during FAULT sets its pending bit. fault_clr → IDLE and the pending dose is dispatched.
- Suppression/validation:
  - time_valid=0 at the match time → no pending.
  - cfg_hours=24 write → slot unchanged.
  - disable write on a pending slot → bit clears, no dispense.
- Races:
  - done and the final timeout tick in the same cycle → IDLE, no fault.
  - a match on the slot being granted in the same cycle → bit stays set, second dispense follows.
- Reset: assert reset mid-WAIT without a clock edge. Required: req=0 immediately; all outputs at reset values; slots disabled.
